column_dispatcher: RTL and testbench

COLUMN_DISPATCHER -- requirements
Module: column_dispatcher

---
 rtl/column_dispatcher.sv | 132 +++++++++++++
 tb/tb_column_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_dispatcher.sv
// rtl/column_dispatcher.sv - round-robin reader of standard-read column FIFOs into a 2-entry output buffer
// Optional COLUMN_DISPATCHER_STATS_EN adds the eor_count end-of-row transfer counter.
module column_dispatcher #(
  parameter int CHANNEL_NUM     = 4,
  parameter int CHANNEL_NUM_LOG = 2,
  parameter int COL_ID_SIZE     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_NUM-1:0]             empty,
  input  logic [COL_ID_SIZE*CHANNEL_NUM-1:0] col_in,
  output logic [CHANNEL_NUM-1:0]             read,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [COL_ID_SIZE-1:0]             out_col,
  output logic [CHANNEL_NUM_LOG-1:0]         out_channel,
  output logic                               out_eor
`ifdef COLUMN_DISPATCHER_STATS_EN
  ,
  output logic [15:0]                        eor_count
`endif
);

  logic [CHANNEL_NUM_LOG-1:0] r_rr;
  logic                       r_inflight_v;
  logic [CHANNEL_NUM_LOG-1:0] r_inflight_ch;
  logic [COL_ID_SIZE-1:0]     r_buf_col [2];
  logic [CHANNEL_NUM_LOG-1:0] r_buf_ch  [2];
  logic                       r_head;
  logic [1:0]                 r_occ;

  logic [COL_ID_SIZE-1:0]     w_col_slice [CHANNEL_NUM];
  logic                       w_pop;
  logic                       w_push;
  logic                       w_tail;
  logic                       w_room;
  logic                       w_grant_v;
  logic [CHANNEL_NUM_LOG-1:0] w_grant_ch;
  logic [CHANNEL_NUM_LOG:0]   w_cand;
  logic [CHANNEL_NUM_LOG:0]   w_rr_sum;
  logic [CHANNEL_NUM_LOG-1:0] w_rr_next;

  genvar g;
  generate
    for (g = 0; g < CHANNEL_NUM; g++) begin : g_chan
      assign w_col_slice[g] = col_in[g*COL_ID_SIZE +: COL_ID_SIZE];
      assign read[g]        = w_grant_v && (w_grant_ch == CHANNEL_NUM_LOG'(g));
    end
  endgenerate

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight_v;
  // With occ=1 the tail is the slot after head; occ=2 never coincides with a push.
  assign w_tail = r_head ^ r_occ[0];
  // Grant only if the beat it produces will still find a free slot next cycle.
  assign w_room = ({1'b0, r_occ} + {2'b00, r_inflight_v}) < (3'd2 + {2'b00, w_pop});

  always_comb begin
    w_grant_v  = 1'b0;
    w_grant_ch = '0;
    w_cand     = '0;
    if (!rst && w_room) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        w_cand = {1'b0, r_rr} + (CHANNEL_NUM_LOG+1)'(k);
        if (w_cand >= (CHANNEL_NUM_LOG+1)'(CHANNEL_NUM)) begin
          w_cand = w_cand - (CHANNEL_NUM_LOG+1)'(CHANNEL_NUM);
        end
        if (!w_grant_v && !empty[w_cand[CHANNEL_NUM_LOG-1:0]]) begin
          w_grant_v  = 1'b1;
          w_grant_ch = w_cand[CHANNEL_NUM_LOG-1:0];
        end
      end
    end
  end

  always_comb begin
    w_rr_sum = {1'b0, w_grant_ch} + (CHANNEL_NUM_LOG+1)'(1);
    if (w_rr_sum >= (CHANNEL_NUM_LOG+1)'(CHANNEL_NUM)) begin
      w_rr_sum = w_rr_sum - (CHANNEL_NUM_LOG+1)'(CHANNEL_NUM);
    end
    w_rr_next = w_rr_sum[CHANNEL_NUM_LOG-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr          <= '0;
      r_inflight_v  <= 1'b0;
      r_inflight_ch <= '0;
      r_head        <= 1'b0;
      r_occ         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_col[i] <= '0;
        r_buf_ch[i]  <= '0;
      end
    end else begin
      if (w_grant_v) begin
        r_rr <= w_rr_next;
      end
      r_inflight_v  <= w_grant_v;
      r_inflight_ch <= w_grant_ch;
      // Standard-read FIFO: last cycle's read shows its data on col_in now.
      if (w_push) begin
        r_buf_col[w_tail] <= w_col_slice[r_inflight_ch];
        r_buf_ch[w_tail]  <= r_inflight_ch;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign out_valid   = (r_occ != 2'd0);
  assign out_col     = r_buf_col[r_head];
  assign out_channel = r_buf_ch[r_head];
  assign out_eor     = &out_col;

`ifdef COLUMN_DISPATCHER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      eor_count <= 16'd0;
    end else if (w_pop && out_eor) begin
      eor_count <= eor_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_column_dispatcher.sv
// tb/tb_column_dispatcher.sv - directed vector table, multi-cycle corner sequences and randomized scoreboard for column_dispatcher
module tb_column_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  empty;
  logic [63:0] col_in;
  logic [3:0]  read;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_col;
  logic [1:0]  out_channel;
  logic        out_eor;
`ifdef COLUMN_DISPATCHER_STATS_EN
  logic [15:0] eor_count;
`endif

  always #5 clk = ~clk;

  column_dispatcher #(
    .CHANNEL_NUM(4),
    .CHANNEL_NUM_LOG(2),
    .COL_ID_SIZE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .empty(empty),
    .col_in(col_in),
    .read(read),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col(out_col),
    .out_channel(out_channel),
    .out_eor(out_eor)
`ifdef COLUMN_DISPATCHER_STATS_EN
    ,
    .eor_count(eor_count)
`endif
  );

  // Either the vector table drives the FIFO side directly, or a standard-read FIFO model does.
  logic        use_model;
  logic [3:0]  t_empty;
  logic [63:0] t_col;
  logic [15:0] fmem [4][64];
  int          fwr [4];
  int          frd [4];
  logic [15:0] fdout [4];
  logic [3:0]  m_empty;
  logic [15:0] exp_q [4][$];

  always_comb begin
    m_empty = 4'b0000;
    for (int i = 0; i < 4; i++) m_empty[i] = (fwr[i] == frd[i]);
  end

  assign empty  = use_model ? m_empty : t_empty;
  assign col_in = use_model ? {fdout[3], fdout[2], fdout[1], fdout[0]} : t_col;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (use_model && read[i]) begin
        fdout[i] <= fmem[i][frd[i] % 64];
        frd[i]   <= frd[i] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] v);
    fmem[ch][fwr[ch] % 64] = v;
    fwr[ch] = fwr[ch] + 1;
    exp_q[ch].push_back(v);
  endtask

  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    use_model = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  emp;
    logic [63:0] col;
    logic        rdy;
    logic [3:0]  rd;
    logic        v;
    logic [15:0] ocol;
    logic [1:0]  och;
    logic        eor;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int          nreads;
    logic [17:0] got [$];
    logic [17:0] exp34 [6];
    logic [17:0] exp36 [2];
    logic [15:0] e;
    int          ch;
    int          left;

    tbl[0]  = '{4'b0100, 64'h0000_0000_0000_0000, 1'b1, 4'b0001, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 64'h0000_0000_0000_0010, 1'b1, 4'b0010, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[2]  = '{4'b0110, 64'h0000_0000_0020_0010, 1'b1, 4'b1000, 1'b1, 16'h0010, 2'd0, 1'b0};
    tbl[3]  = '{4'b1110, 64'h0040_0000_0020_0010, 1'b1, 4'b0001, 1'b1, 16'h0020, 2'd1, 1'b0};
    tbl[4]  = '{4'b1111, 64'h0040_0000_0020_0011, 1'b1, 4'b0000, 1'b1, 16'h0040, 2'd3, 1'b0};
    tbl[5]  = '{4'b1111, 64'h0040_0000_0020_0011, 1'b1, 4'b0000, 1'b1, 16'h0011, 2'd0, 1'b0};
    tbl[6]  = '{4'b1111, 64'h0040_0000_0020_0011, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[7]  = '{4'b1011, 64'h0040_0000_0020_0011, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[8]  = '{4'b1011, 64'h0040_FFFF_0020_0011, 1'b1, 4'b0100, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[9]  = '{4'b1111, 64'h0040_0005_0020_0011, 1'b0, 4'b0000, 1'b1, 16'hFFFF, 2'd2, 1'b1};
    tbl[10] = '{4'b1111, 64'h0040_0005_0020_0011, 1'b0, 4'b0000, 1'b1, 16'hFFFF, 2'd2, 1'b1};
    tbl[11] = '{4'b1111, 64'h0040_0005_0020_0011, 1'b1, 4'b0000, 1'b1, 16'hFFFF, 2'd2, 1'b1};
    tbl[12] = '{4'b1111, 64'h0040_0005_0020_0011, 1'b1, 4'b0000, 1'b1, 16'h0005, 2'd2, 1'b0};
    tbl[13] = '{4'b1111, 64'h0040_0005_0020_0011, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0};

    exp34 = '{{2'd0, 16'h0A00}, {2'd1, 16'h0B00}, {2'd2, 16'h0C00},
              {2'd3, 16'h0D00}, {2'd0, 16'h0A01}, {2'd1, 16'h0B01}};
    exp36 = '{{2'd1, 16'h0E01}, {2'd1, 16'h0E02}};

    rst = 1'b1;
    out_ready = 1'b1;
    use_model = 1'b0;
    t_empty = 4'b0000;
    t_col = 64'h0;

    // Reset state with every channel claiming data
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", read, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_col", out_col, 16'h0000);
    chk("rst_channel", out_channel, 2'd0);
    chk("rst_eor", out_eor, 1'b0);
`ifdef COLUMN_DISPATCHER_STATS_EN
    chk("rst_eor_count", eor_count, 16'd0);
`endif

    // Vector table: arbitration order, 2-cycle latency, eor beat held under backpressure
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = 1'b0;
      t_empty = tbl[i].emp;
      t_col = tbl[i].col;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_read", i), read, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_col", i), out_col, tbl[i].ocol);
        chk($sformatf("tbl%0d_ch", i), out_channel, tbl[i].och);
        chk($sformatf("tbl%0d_eor", i), out_eor, tbl[i].eor);
      end
    end
`ifdef COLUMN_DISPATCHER_STATS_EN
    chk("tbl_eor_count", eor_count, 16'd1);
`endif

    // Eight back-to-back reads from channel 0, one beat per cycle
    begin_reset();
    for (int k = 0; k < 8; k++) push(0, 16'h0100 + 16'(k));
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      chk($sformatf("burst%0d_read", c), read, (c < 8) ? 4'b0001 : 4'b0000);
      chk($sformatf("burst%0d_valid", c), out_valid, (c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        chk($sformatf("burst%0d_col", c), out_col, 16'h0100 + 16'(c - 2));
        chk($sformatf("burst%0d_ch", c), out_channel, 2'd0);
      end
    end

    // Backpressure: only two reads fit, head holds until release
    begin_reset();
    push(0, 16'h0A00); push(0, 16'h0A01);
    push(1, 16'h0B00); push(1, 16'h0B01);
    push(2, 16'h0C00);
    push(3, 16'h0D00);
    nreads = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      #1;
      nreads += $countones(read);
      if (c >= 2) begin
        chk($sformatf("bp%0d_valid", c), out_valid, 1'b1);
        chk($sformatf("bp%0d_head", c), {out_channel, out_col}, {2'd0, 16'h0A00});
      end
    end
    chk("bp_reads", nreads, 2);
    got.delete();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) got.push_back({out_channel, out_col});
    end
    chk("bp_beats", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_beat%0d", i), got[i], exp34[i]);
    end

    // Reset with one beat buffered and one read in flight
    begin_reset();
    push(1, 16'h0E00); push(1, 16'h0E01); push(1, 16'h0E02);
    push(3, 16'h0F00);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rr_first_read", read, 4'b0010);
    @(negedge clk);
    #1;
    chk("rr_second_read", read, 4'b1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_before", out_valid, 1'b1);
    chk("mid_rst_read", read, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_read", read, 4'b0010);
    got.delete();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_valid) got.push_back({out_channel, out_col});
      if (c == 0) #1;
    end
    chk("post_rst_beats", got.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < got.size()) chk($sformatf("post_rst_beat%0d", i), got[i], exp36[i]);
    end

    // Randomized empty/out_ready traffic against the per-channel scoreboard
    begin_reset();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (($urandom % 4 == 0) && (fwr[i] - frd[i] < 60)) push(i, 16'($urandom));
      end
      out_ready = ($urandom % 3) != 0;
      #1;
      chk("rnd_read_on_empty", read & empty, 4'b0000);
      chk("rnd_read_onehot", $onehot0(read), 1'b1);
      if (out_valid && out_ready) begin
        ch = int'(out_channel);
        if (exp_q[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_extra_beat actual=%0h required=none", out_col);
        end else begin
          e = exp_q[ch].pop_front();
          chk("rnd_col", out_col, e);
          chk("rnd_eor", out_eor, e == 16'hFFFF);
        end
      end
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        ch = int'(out_channel);
        if (exp_q[ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_extra_beat actual=%0h required=none", out_col);
        end else begin
          e = exp_q[ch].pop_front();
          chk("drain_col", out_col, e);
        end
      end
    end
    left = 0;
    for (int i = 0; i < 4; i++) left += exp_q[i].size();
    chk("rnd_lost_beats", left, 0);
    chk("rnd_idle_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
